spi_ram_master: RTL
===================

# spi_ram_master

Single-clock SPI master sequencer that drives the `SPI_Wrapper` slave (SPI slave interface plus single-port RAM) from a parallel request/response port. It turns each memory request into the two 10-bit SPI frames the slave requires:
- write: address frame, then data frame;
- read: address frame, then read-data frame with MISO capture.

It sits between on-chip logic and the `SS_N`/`MOSI`/`MISO` pins of `SPI_Wrapper`. It replaces hand-driven bench stimulus as the one owner of the SPI bus.

## Interface
Parameters:
- ADDR_SIZE, 8 — address width and data width. Frame width is ADDR_SIZE+2. Only 8 is supported (matches `SPI_Wrapper`).
- MISO_DELAY, 1 — idle cycles between the last MOSI bit of a read-data frame and the first MISO sample.
- GAP_CYCLES, 2 — cycles `SS_N` is held high after every frame (minimum 1).

Ports (clock and reset first):
- clk  in  1  — system clock; all logic on rising edge.
- rst_n  in  1  — reset, synchronous, active-low.
- req_valid  in  1  — request present.
- req_ready  out  1  — high only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
- req_wr  in  1  — 1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  — RAM address.
- req_wdata  in  ADDR_SIZE  — write data; ignored for reads.
- rsp_valid  out  1  — one-cycle pulse when read data is available.
- rsp_rdata  out  ADDR_SIZE  — read data; holds its value until the next read completes.
- busy  out  1  — inverse of req_ready.
- SS_N  out  1  — slave select, active low.
- MOSI  out  1  — serial data to the slave, MSB first.
- MISO  in  1  — serial data from the slave, MSB first.

## Operation
- States: IDLE, SEL, SHIFT, WAIT_MISO, RECV, GAP, RESP. A phase flag (0 = address frame, 1 = second frame) is held alongside the state.
- On acceptance, the block registers req_wr, req_addr and req_wdata. Later input changes have no effect on the transaction in flight.
- Frames, sent MSB first:
  - write address: {2'b00, addr}
  - write data: {2'b01, wdata}
  - read address: {2'b10, addr}
  - read data: {2'b11, 8'h00}
- IDLE → SEL on acceptance.
- SEL: one cycle; SS_N=0, MOSI=0. → SHIFT.
- SHIFT: exactly 10 cycles; MOSI = frame[9-k] in cycle k. A 4-bit counter counts 0..9.
- After SHIFT:
  - read-data frame → WAIT_MISO;
  - any other frame → GAP with SS_N=1.
- WAIT_MISO: MISO_DELAY cycles; SS_N=0, MOSI=0. → RECV.
- RECV: 8 cycles; SS_N=0. MISO is sampled at the end of each cycle into a shift register, MSB first. → RESP.
- RESP: one cycle; SS_N=1, rsp_valid=1, rsp_rdata = captured byte. → GAP.
- GAP: GAP_CYCLES cycles with SS_N=1, MOSI=0.
  - After phase 0: → SEL with phase 1.
  - After phase 1: → IDLE.
- rsp_valid never asserts for writes.
- Reset (rst_n sampled low), at any state including mid-frame:
  - next state IDLE;
  - SS_N=1, MOSI=0, rsp_valid=0, rsp_rdata=0, all counters 0, phase 0.
  - The partial frame is abandoned; SS_N rising aborts it at the slave.
- Reset values of outputs: req_ready=1, busy=0, SS_N=1, MOSI=0, rsp_valid=0, rsp_rdata=0.

## Timing
- All outputs are registered except req_ready and busy, which are decoded from state.
- Cycle numbers below count from the acceptance edge. Cycle 1 is the first cycle after acceptance. Figures use the default parameters.
- Write:
  - SEL at cycle 1; SHIFT cycles 2–11; GAP 12–13.
  - SEL at 14; SHIFT 15–24; GAP 25–26.
  - req_ready high at cycle 27.
- Read:
  - SEL at cycle 1; SHIFT 2–11; GAP 12–13.
  - SEL at 14; SHIFT 15–24; WAIT_MISO 25; RECV 26–33.
  - rsp_valid at cycle 34; GAP 34–35.
  - req_ready high at cycle 36.
- Back-to-back requests: a request held valid is accepted on the first IDLE edge, so there is no extra bubble. Acceptance can never coincide with rsp_valid.
- SS_N never glitches inside a frame. It stays low continuously from SEL through the end of SHIFT, or through the end of RECV for read-data frames.

## Test plan
- Reset, then idle: hold rst_n=0 for 2 cycles → SS_N=1, MOSI=0, req_ready=1, rsp_valid=0 every cycle.
- Write 0xFD to address 0xFF → MOSI sequence 0011111111, a gap, then 0111111101. SS_N low for 11 cycles per frame. `SPI_Wrapper` RAM[0xFF]=0xFD. req_ready returns at cycle 27.
- Read address 0xFF after preloading RAM[0xFF]=0xAB hierarchically → frames 1011111111 and 1100000000. rsp_valid is a single pulse at cycle 34 with rsp_rdata=0xAB.
- Back-to-back: write 0x00←0x5A, then immediately read 0x00 with req_valid held high → second acceptance at cycle 27, rsp_rdata=0x5A. req_addr changed during busy has no effect.
- Reset mid-frame: assert rst_n=0 at SHIFT bit 4 of a write-data frame → SS_N=1 on the next cycle and state IDLE. A following read of the same address returns the old RAM value.
- Parameter sweep: MISO_DELAY=2, GAP_CYCLES=1 → read of a preloaded 0x3C returns 0x3C. Gaps are exactly 1 cycle.

Source files
------------

// File: rtl/spi_ram_master.sv
// spi_ram_master
// SPI master sequencer for the SPI_Wrapper slave (SPI slave + single-port RAM).
// Each parallel request becomes two 10-bit SPI frames, MSB first:
//   write: {2'b00, addr} then {2'b01, wdata}
//   read : {2'b10, addr} then {2'b11, 8'h00}, followed by an 8-bit MISO capture.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high only in IDLE (decoded from state)
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   RAM address
//   req_wdata  in   write data (ignored for reads)
//   rsp_valid  out  one-cycle pulse when read data is available
//   rsp_rdata  out  last read data, held until the next read completes
//   busy       out  inverse of req_ready
//   SS_N       out  slave select, active low
//   MOSI       out  serial data to slave
//   MISO       in   serial data from slave
module spi_ram_master #(
    parameter int ADDR_SIZE  = 8,
    parameter int MISO_DELAY = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 SS_N,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FW = ADDR_SIZE + 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEL       = 3'd1,
        SHIFT     = 3'd2,
        WAIT_MISO = 3'd3,
        RECV      = 3'd4,
        GAP       = 3'd5,
        RESP      = 3'd6
    } state_e;

    // Frame contents for the given phase of a write or read transaction.
    function automatic logic [FW-1:0] frame_f(
        input logic                 phase,
        input logic                 wr,
        input logic [ADDR_SIZE-1:0] addr,
        input logic [ADDR_SIZE-1:0] wdata
    );
        logic [FW-1:0] f;
        case ({wr, phase})
            2'b10:   f = {2'b00, addr};
            2'b11:   f = {2'b01, wdata};
            2'b00:   f = {2'b10, addr};
            2'b01:   f = {2'b11, {ADDR_SIZE{1'b0}}};
            default: f = {FW{1'b0}};
        endcase
        return f;
    endfunction

    state_e                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic                   wr_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [ADDR_SIZE-1:0]   wdata_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             dly_cnt_q, dly_cnt_d;
    logic [ADDR_SIZE-1:0]   rx_q, rx_d;
    logic                   ss_n_q, ss_n_d;
    logic                   mosi_q, mosi_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [FW-1:0]          frame_s;
    logic [3:0]             bit_idx_s;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign SS_N      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state and next-output decode. Outputs are computed from the next
    // state so that the registered pins line up with the state of each cycle.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        dly_cnt_d = dly_cnt_q;
        rx_d      = rx_q;

        case (state_q)
            IDLE: begin
                phase_d   = 1'b0;
                bit_cnt_d = 4'd0;
                dly_cnt_d = 8'd0;
                if (req_valid) begin
                    state_d = SEL;
                end else begin
                    state_d = IDLE;
                end
            end
            SEL: begin
                bit_cnt_d = 4'd0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == 4'(FW - 1)) begin
                    bit_cnt_d = 4'd0;
                    dly_cnt_d = 8'd0;
                    if (phase_q && !wr_q) begin
                        if (MISO_DELAY == 0) begin
                            state_d = RECV;
                        end else begin
                            state_d = WAIT_MISO;
                        end
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WAIT_MISO: begin
                if (dly_cnt_q == 8'(MISO_DELAY - 1)) begin
                    dly_cnt_d = 8'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = RECV;
                end else begin
                    dly_cnt_d = dly_cnt_q + 8'd1;
                end
            end
            RECV: begin
                rx_d = {rx_q[ADDR_SIZE-2:0], MISO};
                if (bit_cnt_q == 4'(ADDR_SIZE - 1)) begin
                    bit_cnt_d = 4'd0;
                    state_d   = RESP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            RESP: begin
                // The response cycle already has SS_N high, so it counts as
                // the first cycle of the trailing gap.
                if (GAP_CYCLES <= 1) begin
                    phase_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    dly_cnt_d = 8'd1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (dly_cnt_q >= 8'(GAP_CYCLES - 1)) begin
                    dly_cnt_d = 8'd0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        phase_d = 1'b1;
                        state_d = SEL;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frame_s   = frame_f(phase_d, wr_q, addr_q, wdata_q);
        bit_idx_s = 4'(FW - 1) - bit_cnt_d;

        ss_n_d = !((state_d == SEL) || (state_d == SHIFT) ||
                   (state_d == WAIT_MISO) || (state_d == RECV));

        if (state_d == SHIFT) begin
            mosi_d = frame_s[bit_idx_s];
        end else begin
            mosi_d = 1'b0;
        end

        rsp_valid_d = (state_d == RESP);
        if (state_d == RESP) begin
            rsp_rdata_d = rx_d;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // State, counters and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            bit_cnt_q   <= 4'd0;
            dly_cnt_q   <= 8'd0;
            rx_q        <= {ADDR_SIZE{1'b0}};
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {ADDR_SIZE{1'b0}};
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            rx_q        <= rx_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture on acceptance; the transaction in flight is immune to
    // later changes on the request inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= {ADDR_SIZE{1'b0}};
            wdata_q <= {ADDR_SIZE{1'b0}};
        end else if ((state_q == IDLE) && req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end else begin
            wr_q    <= wr_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
        end
    end

endmodule
